// File: rtl/activation_unit.sv
// Purpose : per-lane activation (pass / ReLU / clamped ReLU / leaky ReLU) on a LANES-wide beat, plus a saturating negative-lane counter.
// Latency : 2 cycles from input accept to out_valid; one beat per cycle when out_ready is held high.
// Backpr. : both stages stall together while out_valid && !out_ready; in_ready drops combinationally in that case.
//
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready/in_data  - input beat, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//           mode, clip                 - activation select and clamp bound, captured with the beat
//           out_valid/out_ready/out_data - activated beat, same packing
//           stat_clr, neg_cnt          - synchronous clear / 16-bit saturating negative-lane count
// Macro   : ACT_LEAKY_EN - builds the leaky-ReLU shifter for mode 3; without it mode 3 is plain ReLU.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module activation_unit #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic [1:0]                  mode,
    input  logic [DATA_WIDTH-1:0]       clip,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    input  logic                        stat_clr,
    output logic [15:0]                 neg_cnt
);

    localparam int BW = LANES * DATA_WIDTH;
    localparam int CW = $clog2(LANES + 1);

    // Reject configurations the datapath is not built for.
    if (LANES < 1 || LANES > 16 || LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_WIDTH) begin : g_bad_param
        $error("activation_unit: parameter out of range");
    end

    logic                  en;
    logic                  accept;

    logic                  s1_vld_q,  s1_vld_d;
    logic [BW-1:0]         s1_dat_q,  s1_dat_d;
    logic [1:0]            s1_mode_q, s1_mode_d;
    logic [DATA_WIDTH-1:0] s1_clip_q, s1_clip_d;

    logic                  out_vld_q, out_vld_d;
    logic [BW-1:0]         out_dat_q, out_dat_d;
    logic [15:0]           neg_cnt_q, neg_cnt_d;

    logic [BW-1:0]         act_dat;
    logic [CW-1:0]         neg_lanes;
    logic [16:0]           cnt_sum;

    // One lane of the activation; all compares are signed.
    function automatic logic [DATA_WIDTH-1:0] act_lane(
        input logic [DATA_WIDTH-1:0] x_u,
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] c_u
    );
        logic signed [DATA_WIDTH-1:0] x;
        logic signed [DATA_WIDTH-1:0] c;
        logic signed [DATA_WIDTH-1:0] pos;
        logic signed [DATA_WIDTH-1:0] r;
        x   = signed'(x_u);
        c   = signed'(c_u);
        pos = x[DATA_WIDTH-1] ? '0 : x;
        case (m)
            2'd0:    r = x;
            2'd1:    r = pos;
            // A negative clip would otherwise leak through min(); it forces 0.
            2'd2:    r = c[DATA_WIDTH-1] ? '0 : ((pos > c) ? c : pos);
`ifdef ACT_LEAKY_EN
            // Arithmetic shift floors toward -inf and can never overflow.
            2'd3:    r = x[DATA_WIDTH-1] ? (x >>> LEAK_SHIFT) : x;
`else
            2'd3:    r = pos;
`endif
            default: r = x;
        endcase
        return r;
    endfunction

    // Both stages share one advance enable, so a stall freezes the whole pipe.
    assign en       = !out_vld_q || out_ready;
    assign accept   = in_valid && en;
    assign in_ready = en;

    always_comb begin
        act_dat = '0;
        for (int i = 0; i < LANES; i++) begin
            act_dat[i*DATA_WIDTH +: DATA_WIDTH] =
                act_lane(s1_dat_q[i*DATA_WIDTH +: DATA_WIDTH], s1_mode_q, s1_clip_q);
        end
    end

    always_comb begin
        neg_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            neg_lanes = neg_lanes + CW'(in_data[i*DATA_WIDTH + DATA_WIDTH - 1]);
        end
    end

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_dat_d  = s1_dat_q;
        s1_mode_d = s1_mode_q;
        s1_clip_d = s1_clip_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (en) begin
            s1_vld_d  = in_valid;
            s1_dat_d  = in_data;
            s1_mode_d = mode;
            s1_clip_d = clip;
            out_vld_d = s1_vld_q;
            out_dat_d = act_dat;
        end
    end

    // Clear wins over the old count but not over the beat accepted alongside it.
    always_comb begin
        cnt_sum   = (stat_clr ? 17'd0 : {1'b0, neg_cnt_q}) + 17'(neg_lanes);
        neg_cnt_d = stat_clr ? 16'd0 : neg_cnt_q;
        if (accept) begin
            neg_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s1_mode_q <= '0;
            s1_clip_q <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            neg_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_dat_q  <= s1_dat_d;
            s1_mode_q <= s1_mode_d;
            s1_clip_q <= s1_clip_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            neg_cnt_q <= neg_cnt_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign neg_cnt   = neg_cnt_q;

endmodule

// File: tb/tb_activation_unit.sv
// Purpose : randomized and directed bench for activation_unit against a queue-based reference model.
// Latency : model expects each accepted beat back in order; fixed-latency cases are checked explicitly.
// Backpr. : out_ready is randomized and forced low in windows to exercise hold behaviour.

module tb_activation_unit;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int LS = 3;
    localparam int BW = W * L;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic [1:0]    mode;
    logic [W-1:0]  clip;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          stat_clr;
    logic [15:0]   neg_cnt;

    activation_unit #(.DATA_WIDTH(W), .LANES(L), .LEAK_SHIFT(LS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mode     (mode),
        .clip     (clip),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stat_clr (stat_clr),
        .neg_cnt  (neg_cnt)
    );

    int            checks   = 0;
    int            failures = 0;
    logic [BW-1:0] exp_q[$];
    int            exp_cnt  = 0;
    logic          hold_pend = 1'b0;
    logic [BW-1:0] hold_dat = '0;
    logic          last_acc = 1'b0;
    int            pops     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference activation written from the lane rules with integer arithmetic.
    function automatic logic [BW-1:0] model_beat(input logic [BW-1:0] d, input logic [1:0] m,
                                                  input logic [W-1:0] c);
        logic [BW-1:0]       r;
        logic signed [W-1:0] xs;
        logic signed [W-1:0] cs;
        int                  x, cl, y, dv;
        r  = '0;
        cs = c;
        cl = cs;
        dv = 1 << LS;
        for (int i = 0; i < L; i++) begin
            xs = d[i*W +: W];
            x  = xs;
            case (m)
                2'd0: y = x;
                2'd1: y = (x < 0) ? 0 : x;
                2'd2: y = (cl < 0) ? 0 : ((x < 0) ? 0 : ((x > cl) ? cl : x));
`ifdef ACT_LEAKY_EN
                default: y = (x < 0) ? -((-x + dv - 1) / dv) : x;
`else
                default: y = (x < 0) ? 0 : x;
`endif
            endcase
            r[i*W +: W] = y[W-1:0];
        end
        return r;
    endfunction

    function automatic int count_neg(input logic [BW-1:0] d);
        int n;
        n = 0;
        for (int i = 0; i < L; i++) n += int'(d[i*W + W - 1]);
        return n;
    endfunction

    // One clock of stimulus: check state from the last edge, drive new inputs,
    // then record the handshakes the coming edge will perform.
    task automatic step(input logic v, input logic [BW-1:0] d, input logic [1:0] m,
                        input logic [W-1:0] c, input logic ordy, input logic clr);
        @(negedge clk);
        chk("neg_cnt", 64'(neg_cnt), 64'(exp_cnt));
        if (hold_pend) begin
            chk("hold_vld", 64'(out_valid), 64'd1);
            chk("hold_dat", 64'(out_data), 64'(hold_dat));
        end
        in_valid  = v;
        in_data   = d;
        mode      = m;
        clip      = c;
        out_ready = ordy;
        stat_clr  = clr;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        hold_pend = out_valid && !out_ready;
        hold_dat  = out_data;
        if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
            else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
        last_acc = v && in_ready;
        if (clr) exp_cnt = 0;
        if (last_acc) begin
            exp_q.push_back(model_beat(d, m, c));
            exp_cnt += count_neg(d);
            if (exp_cnt > 65535) exp_cnt = 65535;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 2'd0, '0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) idle();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [BW-1:0] d;
        int            idx;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; clip = '0;
        out_ready = 1'b0; stat_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_neg_cnt", 64'(neg_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // ReLU with a two-cycle latency check.
        step(1'b1, 32'h80FF0001, 2'd1, 8'h00, 1'b1, 1'b0);
        idle();
        chk("r34_bubble", 64'(out_valid), 64'd0);
        idle();
        chk("r34_vld", 64'(out_valid), 64'd1);
        chk("r34_dat", 64'(out_data), 64'h00000001);
        chk("r34_cnt", 64'(neg_cnt), 64'd2);

        // Clamped ReLU, positive and negative clip, back to back.
        step(1'b1, 32'hF07F0605, 2'd2, 8'h06, 1'b1, 1'b0);
        step(1'b1, 32'hF07F0605, 2'd2, 8'hFE, 1'b1, 1'b0);
        idle();
        chk("r35_clip6", 64'(out_data), 64'h00060605);
        idle();
        chk("r35_clipneg", 64'(out_data), 64'h00000000);

        // Leaky ReLU (plain ReLU without the macro).
        step(1'b1, 32'h1080FFF0, 2'd3, 8'h00, 1'b1, 1'b0);
        idle();
        idle();
`ifdef ACT_LEAKY_EN
        chk("r36_leaky", 64'(out_data), 64'h10F0FFFE);
`else
        chk("r36_relu", 64'(out_data), 64'h10000000);
`endif
        drain();

        // Eight beats back to back with a four-cycle downstream stall.
        pops = 0;
        idx  = 0;
        for (int cyc = 0; cyc < 40 && (idx < 8 || exp_q.size() != 0); cyc++) begin
            d = {8'(idx), 8'(8'h80 + idx), 8'(idx * 3), 8'(8'hF0 - idx)};
            step(idx < 8, d, 2'(idx), 8'h20, !(cyc >= 3 && cyc <= 6), 1'b0);
            if (last_acc) idx++;
        end
        drain();
        chk("r37_count", 64'(pops), 64'd8);

        // Saturation: 16383 beats of 4 negatives plus one of 2 reach 0xFFFE.
        step(1'b0, '0, 2'd0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 16383; i++) step(1'b1, 32'h80808080, 2'd0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h80800000, 2'd0, '0, 1'b1, 1'b0);
        idle();
        chk("r38_fffe", 64'(neg_cnt), 64'hFFFE);
        step(1'b1, 32'h80808080, 2'd1, '0, 1'b1, 1'b0);
        idle();
        chk("r38_sat", 64'(neg_cnt), 64'hFFFF);
        step(1'b1, 32'hFFFFFFFF, 2'd1, '0, 1'b1, 1'b0);
        idle();
        chk("r38_hold_sat", 64'(neg_cnt), 64'hFFFF);
        step(1'b1, 32'h80808000, 2'd1, '0, 1'b1, 1'b1);
        idle();
        chk("r38_clr_acc", 64'(neg_cnt), 64'd3);
        step(1'b0, '0, 2'd0, '0, 1'b1, 1'b1);
        idle();
        chk("r38_clr", 64'(neg_cnt), 64'd0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, BW'($urandom), 2'($urandom_range(0, 3)),
                 W'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        drain();

        // Asynchronous reset with beats stalled in flight.
        step(1'b1, 32'h81828384, 2'd0, '0, 1'b0, 1'b0);
        step(1'b1, 32'h85868788, 2'd0, '0, 1'b0, 1'b0);
        step(1'b1, 32'h01020304, 2'd0, '0, 1'b0, 1'b0);
        chk("r39_pre_vld", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r39_vld", 64'(out_valid), 64'd0);
        chk("r39_cnt", 64'(neg_cnt), 64'd0);
        chk("r39_rdy", 64'(in_ready), 64'd1);
        exp_q.delete();
        exp_cnt   = 0;
        hold_pend = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h7F80017E, 2'd1, '0, 1'b1, 1'b0);
        idle();
        chk("r39_bubble", 64'(out_valid), 64'd0);
        idle();
        chk("r39_first", 64'(out_data), 64'h7F00017E);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
